// File: rtl/cr16_fib_sequencer.sv
// Hard-coded control sequencer: loads two seed immediates, then issues ADDs that
// build a Fibonacci series r0..r(LAST_REG) in the cr16 register file, then parks.
module cr16_fib_sequencer #(
    parameter int                      DATA_WIDTH   = 16,
    parameter int                      ALU_OP_WIDTH = 4,
    parameter logic [ALU_OP_WIDTH-1:0] OP_ADD       = 4'h5,
    parameter logic [ALU_OP_WIDTH-1:0] OP_MOV       = 4'hD,
    parameter logic [DATA_WIDTH-1:0]   INIT_A       = 16'd0,
    parameter logic [DATA_WIDTH-1:0]   INIT_B       = 16'd1,
    parameter int                      LAST_REG     = 15
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_enable,
    input  logic [3:0]              i_sel,
    output logic [15:0]             o_wr_en,
    output logic [3:0]              o_rd_addr_a,
    output logic [3:0]              o_rd_addr_b,
    output logic [ALU_OP_WIDTH-1:0] o_alu_op,
    output logic                    o_imm_sel,
    output logic [DATA_WIDTH-1:0]   o_imm,
    output logic [3:0]              o_step,
    output logic                    o_done
);

    if (LAST_REG < 2 || LAST_REG > 15) begin : g_bad_last_reg
        $error("cr16_fib_sequencer: LAST_REG must lie in 2..15");
    end

    localparam logic [3:0] LAST_K = 4'(LAST_REG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT0,
        S_INIT1,
        S_COMPUTE,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_k;
    logic [3:0]  w_k_nxt;
    logic [15:0] w_wr_word;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_k     <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        if (i_enable) begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_INIT0;
                S_INIT0: w_state_nxt = S_INIT1;
                S_INIT1: begin
                    w_state_nxt = S_COMPUTE;
                    w_k_nxt     = 4'd2;
                end
                S_COMPUTE: begin
                    if (r_k == LAST_K) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_k_nxt = r_k + 4'd1;
                    end
                end
                S_DONE:  w_state_nxt = S_DONE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_wr_word   = 16'h0000;
        o_rd_addr_a = 4'd0;
        o_rd_addr_b = 4'd0;
        o_alu_op    = OP_MOV;
        o_imm_sel   = 1'b0;
        o_imm       = '0;
        o_step      = 4'd0;
        o_done      = 1'b0;
        case (r_state)
            S_INIT0: begin
                w_wr_word = 16'h0001;
                o_imm_sel = 1'b1;
                o_imm     = INIT_A;
            end
            S_INIT1: begin
                w_wr_word = 16'h0002;
                o_imm_sel = 1'b1;
                o_imm     = INIT_B;
                o_step    = 4'd1;
            end
            S_COMPUTE: begin
                w_wr_word   = 16'h0001 << r_k;
                o_rd_addr_a = r_k - 4'd1;
                o_rd_addr_b = r_k - 4'd2;
                o_alu_op    = OP_ADD;
                o_step      = r_k;
            end
            S_DONE: begin
                o_rd_addr_a = i_sel;
                o_rd_addr_b = i_sel;
                o_step      = LAST_K;
                o_done      = 1'b1;
            end
            default: ;
        endcase
        // A stalled step must never commit to the register file.
        o_wr_en = i_enable ? w_wr_word : 16'h0000;
    end

endmodule
